mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port if_gnt  output  1  fetch accepted, one-cycle pulse.
REQ-008 SHALL have port if_done  output  1  fetch complete, rdata valid, one-cycle pulse.
REQ-009 SHALL have port d_req  input  1  data access request (LDR/STR/SWP).
REQ-010 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-011 SHALL have port d_lock  input  1  keep port reserved for data after this access (SWP read phase).
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  DATA_W  store data.
REQ-014 SHALL have port d_gnt  output  1  data accepted, one-cycle pulse.
REQ-015 SHALL have port d_done  output  1  data access complete, one-cycle pulse.
REQ-016 SHALL have port rdata  output  DATA_W  registered read data, shared by both requesters.
REQ-017 SHALL have port mem_en  output  1  memory access active.
REQ-018 SHALL have port mem_we  output  1  memory write strobe.
REQ-019 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-020 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-021 SHALL have port mem_rdata  input  DATA_W  memory read data.
REQ-022 SHALL have port mem_ready  input  1  memory completes current access this cycle.
REQ-023 SHALL have port err  output  1  timeout abort flag, one-cycle pulse with the done pulse.

Function
REQ-024 SHALL implement states IDLE, FETCH, DATA, LOCK.
REQ-025 IDLE: d_req sampled -> DATA; else if_req -> FETCH; else stay. Simultaneous requests: data wins, except REQ-029.
REQ-026 On acceptance SHALL latch addr/we/wdata/lock into registers; gnt pulse and mem_en both assert in the first cycle of FETCH/DATA (request sampled cycle N, gnt+mem_en cycle N+1).
REQ-027 mem_en held 1 throughout FETCH/DATA; mem_we = latched d_we in DATA, 0 in FETCH; mem_addr/mem_wdata from latched registers; all held stable until completion.
REQ-028 mem_ready=1 in cycle M -> done pulse in M+1, rdata <= mem_rdata on reads (unchanged on writes); next state IDLE, or LOCK if DATA with latched lock=1. Min latency request-to-done = 2 cycles.
REQ-029 Starvation guard: 2-bit counter of consecutive data grants while if_req=1; at 3, next IDLE arbitration grants fetch; counter clears on any fetch grant or when if_req=0.
REQ-030 LOCK: only d_req accepted (-> DATA); if_req ignored, if_gnt stays 0; lock released when a DATA access with lock=0 completes.
REQ-031 Timeout: 4-bit counter of cycles in FETCH/DATA without mem_ready; reaching TIMEOUT (15) -> done pulse with err=1, rdata <= 0, next state IDLE, lock cleared.
REQ-032 Requesters SHALL hold req until gnt; req deasserted before gnt is dropped without effect; at most one access outstanding.
REQ-033 mem_ready outside FETCH/DATA SHALL be ignored.

Reset
REQ-034 rst SHALL force state IDLE, all outputs 0, all latched registers and counters 0, asynchronously.
REQ-035 Reset mid-access SHALL abort it with no done pulse; first grant possible the cycle after rst deasserts.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum, TIMEOUT=15, STARVE_MAX=3.
REQ-037 Single module; no sub-module required.

Verification
REQ-038 if_req, addr 0x10, mem_ready one cycle after mem_en, mem_rdata 0xE3A01005 -> if_gnt cycle 1, if_done cycle 3, rdata 0xE3A01005, err 0.
REQ-039 if_req and d_req (write 0xAA to 0x40) same cycle -> d_gnt first, mem_we=1, mem_wdata 0xAA; then if_gnt after d_done.
REQ-040 SWP: d_lock=1 read 0x80, if_req held, then d_lock=0 write 0x55 to 0x80 -> no if_gnt between the two accesses; fetch granted after second d_done.
REQ-041 mem_ready held 0 -> done pulse with err=1 after 15 cycles in FETCH, rdata 0, state IDLE.
REQ-042 d_req held continuously with if_req=1 -> exactly 3 data grants then one fetch grant, pattern repeats.
REQ-043 rst asserted mid-DATA -> mem_en 0 immediately, no d_done, clean grant after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2,
      LOCK  = 2'd3
   } arb_state_e;

   localparam int unsigned TIMEOUT    = 15;
   localparam int unsigned STARVE_MAX = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// with SWP locking, fetch starvation guard and access timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_lock,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              err
);

   localparam logic [3:0] TMO_LAST   = 4'(TIMEOUT - 1);
   localparam logic [1:0] STARVE_TOP = 2'(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              lock_q, lock_d;
   logic [1:0]        starve_q, starve_d;
   logic [3:0]        tmo_q, tmo_d;
   logic              if_gnt_q, if_gnt_d;
   logic              d_gnt_q, d_gnt_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic              err_q, err_d;
   logic              take_fetch, take_data, finish;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      we_d       = we_q;
      lock_d     = lock_q;
      starve_d   = starve_q;
      tmo_d      = tmo_q;
      if_gnt_d   = 1'b0;
      d_gnt_d    = 1'b0;
      if_done_d  = 1'b0;
      d_done_d   = 1'b0;
      err_d      = 1'b0;
      take_fetch = 1'b0;
      take_data  = 1'b0;
      finish     = 1'b0;

      case (state_q)
         IDLE: begin
            // A starved fetch beats a pending data request once.
            if (if_req && starve_q == STARVE_TOP) take_fetch = 1'b1;
            else if (d_req)                       take_data  = 1'b1;
            else if (if_req)                      take_fetch = 1'b1;
         end
         LOCK: begin
            if (d_req) take_data = 1'b1;
         end
         FETCH, DATA: begin
            if (mem_ready) begin
               finish  = 1'b1;
               state_d = (state_q == DATA && lock_q) ? LOCK : IDLE;
               if (!we_q) rdata_d = mem_rdata;
            end else if (tmo_q == TMO_LAST) begin
               finish  = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
               lock_d  = 1'b0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 4'd1;
            end
         end
         default: ;
      endcase

      if (finish) begin
         if_done_d = (state_q == FETCH);
         d_done_d  = (state_q == DATA);
      end

      if (take_data) begin
         state_d = DATA;
         addr_d  = d_addr;
         we_d    = d_we;
         wdata_d = d_wdata;
         lock_d  = d_lock;
         tmo_d   = '0;
         d_gnt_d = 1'b1;
      end else if (take_fetch) begin
         state_d  = FETCH;
         addr_d   = if_addr;
         we_d     = 1'b0;
         lock_d   = 1'b0;
         tmo_d    = '0;
         if_gnt_d = 1'b1;
      end

      if (!if_req || take_fetch)              starve_d = '0;
      else if (take_data && starve_q != STARVE_TOP) starve_d = starve_q + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         lock_q    <= 1'b0;
         starve_q  <= '0;
         tmo_q     <= '0;
         if_gnt_q  <= 1'b0;
         d_gnt_q   <= 1'b0;
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         we_q      <= we_d;
         lock_q    <= lock_d;
         starve_q  <= starve_d;
         tmo_q     <= tmo_d;
         if_gnt_q  <= if_gnt_d;
         d_gnt_q   <= d_gnt_d;
         if_done_q <= if_done_d;
         d_done_q  <= d_done_d;
         err_q     <= err_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_en    = (state_q == FETCH) || (state_q == DATA);
   assign mem_we    = (state_q == DATA) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grant/done
// events; a negedge monitor pops and compares them as the DUT pulses.
module tb_mem_port_arbiter;

   typedef enum int {EV_IF_GNT = 0, EV_D_GNT = 1, EV_IF_DONE = 2, EV_D_DONE = 3} ev_e;

   typedef struct {
      string       tag;
      ev_e         kind;
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, d_lock;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_gnt, if_done, d_gnt, d_done, err;
   logic [31:0] rdata;
   logic        mem_en, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          t0 = 0;
   int          ready_delay = 0;
   int          busy = 0;
   logic        stray_ready = 1'b0;
   logic        if_keep = 1'b0;
   logic        d_keep = 1'b0;
   exp_t        sb[$];
   logic [31:0] mem_model [logic [31:0]];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_done   (if_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_lock    (d_lock),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_done    (d_done),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push(input string tag, input ev_e k, input int rel, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd, input logic e);
      exp_t x;
      x.tag = tag; x.kind = k; x.cyc = t0 + rel; x.we = we;
      x.addr = addr; x.wdata = wdata; x.rdata = rd; x.err = e;
      sb.push_back(x);
   endtask

   // Memory model: ready after ready_delay extra cycles of mem_en (-1 = never).
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            if (busy == ready_delay) begin
               mem_ready = 1'b1;
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
               busy = 0;
            end else begin
               mem_ready = 1'b0;
               busy++;
            end
         end else begin
            mem_ready = stray_ready;
            busy = 0;
            if (stray_ready) mem_rdata = 32'hDEAD_DEAD;
         end
      end
   end

   // Monitor: every grant/done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      ev_e  act_k;
      exp_t e;
      if (!rst) begin
         if (err && !(if_done || d_done)) check("err_without_done", 64'(err), 64'd0);
         if (if_gnt || d_gnt || if_done || d_done) begin
            act_k = if_gnt ? EV_IF_GNT : d_gnt ? EV_D_GNT : if_done ? EV_IF_DONE : EV_D_DONE;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event kind=%0d cycle=%0d expected=none", act_k, cyc);
            end else begin
               e = sb.pop_front();
               check({e.tag, "_kind"}, 64'(act_k), 64'(e.kind));
               check({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
               if (act_k == EV_IF_GNT || act_k == EV_D_GNT) begin
                  check({e.tag, "_mem_en"}, 64'(mem_en), 64'd1);
                  check({e.tag, "_mem_we"}, 64'(mem_we), 64'(e.we));
                  check({e.tag, "_mem_addr"}, 64'(mem_addr), 64'(e.addr));
                  if (e.we) check({e.tag, "_mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
               end else begin
                  check({e.tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
                  check({e.tag, "_err"}, 64'(err), 64'(e.err));
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (if_gnt && !if_keep) if_req = 1'b0;
      if (d_gnt && !d_keep) d_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start();
      t0 = cyc;
   endtask

   task automatic req_if(input logic [31:0] a);
      if_addr = a;
      if_req  = 1'b1;
   endtask

   task automatic req_d(input logic we, input logic lock, input logic [31:0] a, input logic [31:0] wd);
      d_we    = we;
      d_lock  = lock;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      check({name, "_drain"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
      mem_model[32'h10]  = 32'hE3A0_1005;
      mem_model[32'h14]  = 32'hE59F_0004;
      mem_model[32'h80]  = 32'h1234_5678;
      mem_model[32'h100] = 32'hCAFE_F00D;
      mem_model[32'h200] = 32'h0BAD_BEEF;

      #1;
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_gnts", 64'({if_gnt, d_gnt}), 64'd0);
      check("rst_dones", 64'({if_done, d_done, err}), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      idle(2);
      rst = 1'b0;
      idle(2);

      // Single fetch, memory ready one cycle after mem_en.
      ready_delay = 1;
      start(); req_if(32'h10);
      push("fetch_gnt", EV_IF_GNT, 1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
      push("fetch_done", EV_IF_DONE, 3, 1'b0, 32'h0, 32'h0, 32'hE3A0_1005, 1'b0);
      drain("fetch", 20);
      idle(3);

      // Simultaneous fetch and data write: data first, then fetch.
      ready_delay = 0;
      start(); req_if(32'h14); req_d(1'b1, 1'b0, 32'h40, 32'hAA);
      push("both_d_gnt", EV_D_GNT, 1, 1'b1, 32'h40, 32'hAA, 32'h0, 1'b0);
      push("both_d_done", EV_D_DONE, 2, 1'b0, 32'h0, 32'h0, 32'hE3A0_1005, 1'b0);
      push("both_if_gnt", EV_IF_GNT, 3, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
      push("both_if_done", EV_IF_DONE, 4, 1'b0, 32'h0, 32'h0, 32'hE59F_0004, 1'b0);
      drain("both", 20);
      check("both_mem_written", 64'(mem_model[32'h40]), 64'hAA);
      idle(3);

      // SWP: locked read, fetch held off through LOCK, unlocked write, then fetch.
      start(); req_if(32'h14); req_d(1'b0, 1'b1, 32'h80, 32'h0);
      push("swp_rd_gnt", EV_D_GNT, 1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0);
      push("swp_rd_done", EV_D_DONE, 2, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
      drain("swp_rd", 20);
      idle(3);
      check("swp_lock_if_req_held", 64'(if_req), 64'd1);
      start(); req_d(1'b1, 1'b0, 32'h80, 32'h55);
      push("swp_wr_gnt", EV_D_GNT, 1, 1'b1, 32'h80, 32'h55, 32'h0, 1'b0);
      push("swp_wr_done", EV_D_DONE, 2, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
      push("swp_if_gnt", EV_IF_GNT, 3, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
      push("swp_if_done", EV_IF_DONE, 4, 1'b0, 32'h0, 32'h0, 32'hE59F_0004, 1'b0);
      drain("swp_wr", 20);
      idle(3);

      // Fetch timeout: 15 cycles in FETCH, then done with err and rdata cleared.
      ready_delay = -1;
      start(); req_if(32'h20);
      push("tmo_gnt", EV_IF_GNT, 1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
      push("tmo_done", EV_IF_DONE, 16, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      drain("tmo", 40);
      check("tmo_idle_mem_en", 64'(mem_en), 64'd0);
      idle(3);

      // Timeout of a locked read releases the lock so the fetch proceeds.
      start(); req_if(32'h24); req_d(1'b0, 1'b1, 32'h80, 32'h0);
      push("lktmo_d_gnt", EV_D_GNT, 1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0);
      push("lktmo_d_done", EV_D_DONE, 16, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      push("lktmo_if_gnt", EV_IF_GNT, 17, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0);
      push("lktmo_if_done", EV_IF_DONE, 32, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      drain("lktmo", 60);
      idle(3);

      // Starvation guard: both held, three data grants then one fetch, repeating.
      ready_delay = 0;
      if_keep = 1'b1; d_keep = 1'b1;
      start(); req_if(32'h200); req_d(1'b0, 1'b0, 32'h100, 32'h0);
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 3; k++) begin
            push($sformatf("starve_d_gnt%0d_%0d", r, k), EV_D_GNT, 8*r + 2*k + 1,
                 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
            push($sformatf("starve_d_done%0d_%0d", r, k), EV_D_DONE, 8*r + 2*k + 2,
                 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
         end
         push($sformatf("starve_if_gnt%0d", r), EV_IF_GNT, 8*r + 7, 1'b0, 32'h200, 32'h0, 32'h0, 1'b0);
         push($sformatf("starve_if_done%0d", r), EV_IF_DONE, 8*r + 8, 1'b0, 32'h0, 32'h0, 32'h0BAD_BEEF, 1'b0);
      end
      while (cyc < t0 + 16) tick();
      if_req = 1'b0; d_req = 1'b0;
      if_keep = 1'b0; d_keep = 1'b0;
      drain("starve", 10);
      idle(3);

      // mem_ready while idle must be ignored.
      stray_ready = 1'b1;
      idle(4);
      stray_ready = 1'b0;
      idle(2);
      check("stray_rdata", 64'(rdata), 64'h0BAD_BEEF);
      check("stray_err", 64'(err), 64'd0);

      // Reset during a data access: abort with no done, clean grant afterwards.
      ready_delay = -1;
      start(); req_d(1'b0, 1'b0, 32'h40, 32'h0);
      push("rstmid_gnt", EV_D_GNT, 1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
      while (cyc < t0 + 3) tick();
      rst = 1'b1;
      #1;
      check("rstmid_mem_en", 64'(mem_en), 64'd0);
      check("rstmid_done", 64'({d_done, if_done, err}), 64'd0);
      check("rstmid_rdata", 64'(rdata), 64'd0);
      idle(2);
      rst = 1'b0;
      check("rstmid_sb_empty", 64'(sb.size()), 64'd0);
      ready_delay = 0;
      start(); req_d(1'b1, 1'b0, 32'h44, 32'h77);
      push("postrst_gnt", EV_D_GNT, 1, 1'b1, 32'h44, 32'h77, 32'h0, 1'b0);
      push("postrst_done", EV_D_DONE, 2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      drain("postrst", 20);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
